// File: rtl/usb_bridge_pkg.sv
// Shared definitions for the USB register bridge: FSM encoding, default
// parameter values, strobe bit positions and the access-counter width.
package usb_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RDWAIT  = 2'd1,
        RDDRIVE = 2'd2
    } state_t;

    localparam int unsigned DEF_SYNC_STAGES = 2;
    localparam int unsigned DEF_BYTECNT_W   = 16;
    localparam int unsigned ACCESS_CNT_W    = 16;

    // Bit positions of the strobes inside the synchronised strobe vector
    localparam int unsigned STB_RD  = 0;
    localparam int unsigned STB_WR  = 1;
    localparam int unsigned STB_CE  = 2;
    localparam int unsigned STB_ALE = 3;

endpackage

// File: rtl/usb_reg_bridge_if.sv
// Host-side USB parallel bus (address, host data, active-low strobes).
// The bidirectional data net itself stays outside as a resolved wire.
interface usb_reg_bridge_if;
    logic [7:0] addr;
    logic [7:0] host_d;
    logic       host_d_en;
    logic       rd_n;
    logic       wr_n;
    logic       ce_n;
    logic       ale_n;

    modport master (
        output addr, host_d, host_d_en, rd_n, wr_n, ce_n, ale_n
    );

    modport slave (
        input addr, host_d, host_d_en, rd_n, wr_n, ce_n, ale_n
    );
endinterface

// File: rtl/usb_sync_edge.sv
// Multi-flop synchroniser plus one edge-detect stage; edges are suppressed
// until every stage holds a post-reset bus sample.
module usb_sync_edge #(
    parameter int unsigned      WIDTH     = 1,
    parameter int unsigned      STAGES    = 2,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    logic [WIDTH-1:0] sync [STAGES];
    logic [WIDTH-1:0] q_d;
    logic [STAGES:0]  fill;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < STAGES; i++) sync[i] <= RESET_VAL;
            q_d  <= RESET_VAL;
            fill <= '0;
        end else begin
            sync[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) sync[i] <= sync[i-1];
            q_d  <= sync[STAGES-1];
            fill <= {fill[STAGES-1:0], 1'b1};
        end
    end

    assign q    = sync[STAGES-1];
    assign rise = fill[STAGES] ? (q & ~q_d) : '0;
    assign fall = fill[STAGES] ? (~q & q_d) : '0;

endmodule

// File: rtl/usb_reg_bridge.sv
// Asynchronous USB parallel bus to single-cycle register strobes bridge.
// Optional access counter enabled by defining USB_BRIDGE_ACCESS_CNT_EN.
module usb_reg_bridge
    import usb_bridge_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int unsigned BYTECNT_W   = DEF_BYTECNT_W
) (
    input  logic                    clk_usb,
    input  logic                    reset_n,
    inout  wire  [7:0]              USB_D,
    input  logic [7:0]              USB_Addr,
    input  logic                    USB_RDn,
    input  logic                    USB_WRn,
    input  logic                    USB_CEn,
    input  logic                    USB_ALEn,
    output logic [7:0]              reg_address,
    output logic [BYTECNT_W-1:0]    reg_bytecnt,
    output logic [7:0]              reg_datao,
    input  logic [7:0]              reg_datai,
    output logic                    reg_read,
    output logic                    reg_write,
    output logic                    proto_err,
    output logic [ACCESS_CNT_W-1:0] access_cnt
);

    logic [3:0]  stb_s, stb_rise, stb_fall;
    logic [15:0] ad_s, ad_rise, ad_fall;

    usb_sync_edge #(.WIDTH(4), .STAGES(SYNC_STAGES), .RESET_VAL(4'hF)) u_sync_stb (
        .clk   (clk_usb),
        .rst_n (reset_n),
        .d     ({USB_ALEn, USB_CEn, USB_WRn, USB_RDn}),
        .q     (stb_s),
        .rise  (stb_rise),
        .fall  (stb_fall)
    );

    usb_sync_edge #(.WIDTH(16), .STAGES(SYNC_STAGES), .RESET_VAL(16'h0000)) u_sync_ad (
        .clk   (clk_usb),
        .rst_n (reset_n),
        .d     ({USB_Addr, USB_D}),
        .q     (ad_s),
        .rise  (ad_rise),
        .fall  (ad_fall)
    );

    logic unused_sync;
    assign unused_sync = ^{stb_rise, stb_fall, ad_rise, ad_fall};

    logic ale_rise, ale_fall, wr_rise, rd_fall, rd_rise, ce_rise, ce_low;
    logic start_conflict, rd_exit;
    state_t     state;
    logic [7:0] dout;
    logic       oe;

    assign ale_rise = stb_rise[STB_ALE];
    assign ale_fall = stb_fall[STB_ALE];
    assign wr_rise  = stb_rise[STB_WR];
    assign rd_fall  = stb_fall[STB_RD];
    assign rd_rise  = stb_rise[STB_RD];
    assign ce_rise  = stb_rise[STB_CE];
    assign ce_low   = ~stb_s[STB_CE];

    // An ALE edge landing with an access-starting edge wins; the access is dropped
    assign start_conflict = (ale_rise | ale_fall) & ce_low & (wr_rise | rd_fall);
    assign rd_exit        = (state == RDDRIVE) & (rd_rise | ce_rise);

    // Gating on the live synchronised levels releases the bus in the exit cycle itself
    assign USB_D = (oe && !stb_s[STB_RD] && !stb_s[STB_CE]) ? dout : 8'hzz;

    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            reg_read    <= 1'b0;
            reg_write   <= 1'b0;
            proto_err   <= 1'b0;
            reg_address <= '0;
            reg_datao   <= '0;
            reg_bytecnt <= '0;
            dout        <= '0;
            oe          <= 1'b0;
        end else begin
            reg_read  <= 1'b0;
            reg_write <= 1'b0;

            if (ale_rise) reg_address <= ad_s[15:8];

            if (ale_fall)
                reg_bytecnt <= '0;
            else if ((reg_write || rd_exit) && !(&reg_bytecnt))
                reg_bytecnt <= reg_bytecnt + BYTECNT_W'(1);

            case (state)
                IDLE: begin
                    if (start_conflict) begin
                        proto_err <= 1'b1;
                    end else if (ce_low && wr_rise) begin
                        reg_datao <= ad_s[7:0];
                        reg_write <= 1'b1;
                    end else if (ce_low && rd_fall) begin
                        reg_read <= 1'b1;
                        state    <= RDWAIT;
                    end
                end
                RDWAIT: begin
                    if (wr_rise) proto_err <= 1'b1;
                    dout  <= reg_datai;
                    oe    <= 1'b1;
                    state <= RDDRIVE;
                end
                RDDRIVE: begin
                    if (wr_rise) proto_err <= 1'b1;
                    if (rd_exit) begin
                        oe    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: begin
                    oe    <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef USB_BRIDGE_ACCESS_CNT_EN
    always_ff @(posedge clk_usb or negedge reset_n) begin
        if (!reset_n)
            access_cnt <= '0;
        else if (reg_write || rd_exit)
            access_cnt <= access_cnt + ACCESS_CNT_W'(1);
    end
`else
    assign access_cnt = '0;
`endif

endmodule

// File: tb/tb_usb_reg_bridge.sv
// Directed plus randomized bench for usb_reg_bridge with a transaction-level
// model; released bus reads back as 0xFF through pull-ups.
module tb_usb_reg_bridge;

    localparam int unsigned BW = 3;

    logic             clk = 1'b0;
    logic             reset_n;
    wire  [7:0]       usb_d;
    logic [7:0]       reg_address, reg_datao, reg_datai;
    logic [BW-1:0]    reg_bytecnt;
    logic             reg_read, reg_write, proto_err;
    logic [15:0]      access_cnt;

    usb_reg_bridge_if bus ();

    always #5 clk = ~clk;

    for (genvar i = 0; i < 8; i++) begin : g_pu
        pullup (usb_d[i]);
    end
    assign usb_d = bus.host_d_en ? bus.host_d : 8'hzz;

    usb_reg_bridge #(.SYNC_STAGES(2), .BYTECNT_W(BW)) dut (
        .clk_usb     (clk),
        .reset_n     (reset_n),
        .USB_D       (usb_d),
        .USB_Addr    (bus.addr),
        .USB_RDn     (bus.rd_n),
        .USB_WRn     (bus.wr_n),
        .USB_CEn     (bus.ce_n),
        .USB_ALEn    (bus.ale_n),
        .reg_address (reg_address),
        .reg_bytecnt (reg_bytecnt),
        .reg_datao   (reg_datao),
        .reg_datai   (reg_datai),
        .reg_read    (reg_read),
        .reg_write   (reg_write),
        .proto_err   (proto_err),
        .access_cnt  (access_cnt)
    );

    int n_cmp = 0;
    int n_err = 0;

    // Register-file side: returns the next queued value one cycle after reg_read
    logic [7:0] rdq [$];
    int wr_pulses = 0, rd_pulses = 0, wr_run = 0, wr_max = 0;
    initial reg_datai = 8'h00;
    always @(negedge clk) begin
        if (reg_read) begin
            rd_pulses++;
            reg_datai = (rdq.size() > 0) ? rdq.pop_front() : 8'h00;
        end
        if (reg_write) begin
            wr_pulses++;
            wr_run++;
            if (wr_run > wr_max) wr_max = wr_run;
        end else begin
            wr_run = 0;
        end
    end

    // Transaction-level model state
    logic [7:0]  m_addr, m_datao;
    int          m_cnt, m_wr, m_rd;
    logic        m_perr;
    logic [15:0] m_acc;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [15:0] acc_exp();
`ifdef USB_BRIDGE_ACCESS_CNT_EN
        return m_acc;
`else
        return 16'h0000;
`endif
    endfunction

    function automatic int sat_inc(input int c);
        return (c >= (1 << BW) - 1) ? c : c + 1;
    endfunction

    task automatic model_reset();
        m_addr = 8'h00; m_datao = 8'h00; m_cnt = 0; m_perr = 1'b0; m_acc = 16'h0000;
    endtask

    task automatic do_ale(input logic [7:0] a);
        bus.addr  = a;
        bus.ale_n = 1'b0;
        cyc(6);
        chk("ale_low_bytecnt", 32'(reg_bytecnt), 32'd0);
        chk("ale_low_addr_held", 32'(reg_address), 32'(m_addr));
        bus.ale_n = 1'b1;
        cyc(6);
        m_addr = a;
        m_cnt  = 0;
        chk("ale_addr", 32'(reg_address), 32'(m_addr));
    endtask

    task automatic do_wr(input logic [7:0] d);
        bus.host_d    = d;
        bus.host_d_en = 1'b1;
        bus.wr_n      = 1'b0;
        cyc(4);
        bus.wr_n = 1'b1;
        cyc(6);
        bus.host_d_en = 1'b0;
        cyc(2);
        m_datao = d;
        m_cnt   = sat_inc(m_cnt);
        m_acc   = m_acc + 16'd1;
        m_wr++;
        chk("wr_datao", 32'(reg_datao), 32'(m_datao));
        chk("wr_bytecnt", 32'(reg_bytecnt), 32'(m_cnt));
        chk("wr_pulses", 32'(wr_pulses), 32'(m_wr));
    endtask

    task automatic do_rd(input logic [7:0] d);
        rdq.push_back(d);
        bus.rd_n = 1'b0;
        cyc(8);
        m_rd++;
        chk("rd_drive", 32'(usb_d), 32'(d));
        chk("rd_pulses", 32'(rd_pulses), 32'(m_rd));
        bus.rd_n = 1'b1;
        cyc(6);
        m_cnt = sat_inc(m_cnt);
        m_acc = m_acc + 16'd1;
        chk("rd_release", 32'(usb_d), 32'hFF);
        chk("rd_bytecnt", 32'(reg_bytecnt), 32'(m_cnt));
    endtask

    initial begin
        m_wr = 0; m_rd = 0;
        model_reset();
        bus.addr = 8'h00; bus.host_d = 8'h00; bus.host_d_en = 1'b0;
        bus.rd_n = 1'b1; bus.wr_n = 1'b1; bus.ce_n = 1'b1; bus.ale_n = 1'b1;
        reset_n = 1'b0;
        cyc(3);
        chk("rst_addr", 32'(reg_address), 32'd0);
        chk("rst_bytecnt", 32'(reg_bytecnt), 32'd0);
        chk("rst_datao", 32'(reg_datao), 32'd0);
        chk("rst_strobes", {29'd0, reg_read, reg_write, proto_err}, 32'd0);
        chk("rst_acc", 32'(access_cnt), 32'd0);
        chk("rst_bus_z", 32'(usb_d), 32'hFF);
        reset_n = 1'b1;
        cyc(6);
        bus.ce_n = 1'b0;
        cyc(6);

        // Address then single write
        do_ale(8'h2A);
        do_wr(8'hA5);
        chk("wr_width", 32'(wr_max), 32'd1);

        // Three reads from one register, then a new ALE phase
        do_ale(8'h05);
        do_rd(8'h11);
        do_rd(8'h22);
        do_rd(8'h33);
        chk("rd3_bytecnt", 32'(reg_bytecnt), 32'd3);
        do_ale(8'h77);

        // Byte counter saturates at all-ones
        for (int i = 0; i < 9; i++) do_wr(8'(8'h40 + i));
        chk("sat_bytecnt", 32'(reg_bytecnt), 32'd7);

        // Read ended by CEn going high while RDn is still low
        rdq.push_back(8'h44);
        bus.rd_n = 1'b0;
        cyc(8);
        m_rd++;
        chk("ce_rd_drive", 32'(usb_d), 32'h44);
        bus.ce_n = 1'b1;
        cyc(5);
        m_acc = m_acc + 16'd1;
        chk("ce_exit_release", 32'(usb_d), 32'hFF);
        chk("ce_exit_bytecnt", 32'(reg_bytecnt), 32'd7);
        bus.rd_n = 1'b1;
        cyc(4);
        bus.ce_n = 1'b0;
        cyc(6);

        // ALEn falling edge in the same cycle as a WRn rising edge
        bus.host_d = 8'h99; bus.host_d_en = 1'b1;
        bus.wr_n = 1'b0;
        cyc(4);
        bus.wr_n  = 1'b1;
        bus.ale_n = 1'b0;
        bus.addr  = 8'h3C;
        cyc(6);
        bus.host_d_en = 1'b0;
        m_perr = 1'b1; m_cnt = 0;
        chk("conflict_no_write", 32'(wr_pulses), 32'(m_wr));
        chk("conflict_perr", 32'(proto_err), 32'(m_perr));
        chk("conflict_datao", 32'(reg_datao), 32'(m_datao));
        bus.ale_n = 1'b1;
        cyc(6);
        m_addr = 8'h3C;
        chk("conflict_addr", 32'(reg_address), 32'(m_addr));
        do_wr(8'h5A);
        chk("perr_sticky", 32'(proto_err), 32'd1);

        // Reset pulsed while the bridge drives the bus
        rdq.push_back(8'h66);
        bus.rd_n = 1'b0;
        cyc(8);
        m_rd++;
        chk("rst_rd_drive", 32'(usb_d), 32'h66);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        chk("rst_async_release", 32'(usb_d), 32'hFF);
        chk("rst_mid_outs", {reg_address, reg_datao, 5'(reg_bytecnt), reg_read, reg_write, proto_err}, 32'd0);
        chk("rst_mid_acc", 32'(access_cnt), 32'd0);
        cyc(2);
        reset_n = 1'b1;
        cyc(8);
        chk("no_edge_after_rst", 32'(rd_pulses), 32'(m_rd));
        chk("rst_bus_still_z", 32'(usb_d), 32'hFF);
        bus.rd_n = 1'b1;
        cyc(6);
        chk("perr_cleared", 32'(proto_err), 32'd0);

        // Five writes plus four reads from a clean counter
        do_ale(8'h10);
        for (int i = 0; i < 5; i++) do_wr(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) do_rd(8'($urandom_range(0, 254)));
        chk("acc_9", 32'(access_cnt), 32'(acc_exp()));

        // Random mix of address phases, writes and reads
        for (int i = 0; i < 30; i++) begin
            case ($urandom_range(0, 3))
                0:       do_ale(8'($urandom_range(0, 255)));
                1, 2:    do_wr(8'($urandom_range(0, 255)));
                default: do_rd(8'($urandom_range(0, 254)));
            endcase
        end
        chk("rand_acc", 32'(access_cnt), 32'(acc_exp()));
        chk("rand_perr", 32'(proto_err), 32'(m_perr));

        // WRn rising edge while a read is in progress
        rdq.push_back(8'h5C);
        bus.rd_n = 1'b0;
        cyc(8);
        m_rd++;
        bus.wr_n = 1'b0;
        cyc(4);
        bus.wr_n = 1'b1;
        cyc(6);
        m_perr = 1'b1;
        chk("rdwr_drive", 32'(usb_d), 32'h5C);
        chk("rdwr_no_write", 32'(wr_pulses), 32'(m_wr));
        chk("rdwr_perr", 32'(proto_err), 32'(m_perr));
        bus.rd_n = 1'b1;
        cyc(6);
        m_cnt = sat_inc(m_cnt);
        m_acc = m_acc + 16'd1;
        chk("rdwr_bytecnt", 32'(reg_bytecnt), 32'(m_cnt));
        chk("final_acc", 32'(access_cnt), 32'(acc_exp()));
        chk("final_wr_width", 32'(wr_max), 32'd1);
        chk("final_rd_pulses", 32'(rd_pulses), 32'(m_rd));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/usb_reg_bridge.md
USB_REG_BRIDGE -- requirements
Module: usb_reg_bridge

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2, the number of synchroniser flops on every USB bus input (legal values 2..3).
REQ-002 SHALL have parameter BYTECNT_W, default 16, the width of reg_bytecnt.
REQ-003 SHALL have port clk_usb, input, 1 bit: the single clock; all logic runs on its rising edge.
REQ-004 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port USB_D, inout, 8 bits: the external data bus.
REQ-006 SHALL have port USB_Addr, input, 8 bits: the external address bus.
REQ-007 SHALL have ports USB_RDn, USB_WRn, USB_CEn and USB_ALEn, inputs, 1 bit each, all active-low bus strobes.
REQ-008 SHALL have port reg_address, output, 8 bits: the latched register address.
REQ-009 SHALL have port reg_bytecnt, output, BYTECNT_W bits: the byte index within a multi-byte register.
REQ-010 SHALL have port reg_datao, output, 8 bits: write data.
REQ-011 SHALL have port reg_datai, input, 8 bits: read data from the register file, valid one cycle after reg_read.
REQ-012 SHALL have ports reg_read and reg_write, outputs, 1 bit each, single-cycle strobes.
REQ-013 SHALL have port proto_err, output, 1 bit: sticky bus-protocol-violation flag.
REQ-014 SHALL have port access_cnt, output, 16 bits: count of completed accesses (see Configuration).

Function
REQ-015 SHALL pass USB_Addr, USB_D (input side) and all four strobes through a SYNC_STAGES-deep synchroniser, then one extra register stage used for edge detection.
REQ-016 SHALL load reg_address from the synchronised USB_Addr on a synchronised USB_ALEn rising edge.
REQ-017 SHALL clear reg_bytecnt on a synchronised USB_ALEn falling edge.
REQ-018 SHALL use FSM states IDLE, RDWAIT and RDDRIVE.
REQ-019 In IDLE, on a synchronised USB_WRn rising edge with synchronised USB_CEn low, SHALL load reg_datao from the synchronised data and assert reg_write for exactly the next cycle; SHALL increment reg_bytecnt in the cycle after reg_write; SHALL remain in IDLE.
REQ-020 In IDLE, on a synchronised USB_RDn falling edge with synchronised USB_CEn low, SHALL assert reg_read for one cycle and go to RDWAIT.
REQ-021 In RDWAIT, SHALL register reg_datai into the output data register, assert the USB_D output enable, and go to RDDRIVE.
REQ-022 In RDDRIVE, SHALL drive the output data register onto USB_D while synchronised USB_RDn is low.
REQ-023 In RDDRIVE, on a synchronised USB_RDn rising edge or USB_CEn going high, SHALL release USB_D (high-Z) the same cycle, increment reg_bytecnt, and return to IDLE.
REQ-024 USB_D SHALL be high-Z in every state other than RDDRIVE-with-enable.
REQ-025 reg_bytecnt SHALL saturate at all-ones and never wrap.
REQ-026 If an ALEn edge coincides with an RD or WR edge, ALEn handling SHALL take priority, the access SHALL be dropped, and proto_err SHALL be set.
REQ-027 A WRn rising edge detected while in RDWAIT or RDDRIVE SHALL be ignored and SHALL set proto_err.
REQ-028 proto_err SHALL clear only on reset.

Reset
REQ-029 While reset_n is low: FSM = IDLE; reg_read, reg_write, proto_err = 0; reg_address, reg_datao, reg_bytecnt, access_cnt = 0; USB_D high-Z; synchroniser strobe flops preset to 1 (inactive).
REQ-030 Assertion of reset_n mid-read SHALL release USB_D immediately, without waiting for a clock edge.
REQ-031 After reset deassertion, no edge SHALL be detected until the synchronisers have filled with real bus values.

Configuration
REQ-032 Macro USB_BRIDGE_ACCESS_CNT_EN defined: access_cnt SHALL increment by one on each reg_write and on each RDDRIVE exit, wrapping modulo 2^16.
REQ-033 Macro USB_BRIDGE_ACCESS_CNT_EN undefined: access_cnt SHALL be constant 0 and no counter logic SHALL be built.

Structure
REQ-034 Shared package usb_bridge_pkg SHALL hold the FSM state encoding, the default SYNC_STAGES and BYTECNT_W values, and the access-counter width.
REQ-035 A sub-module usb_sync_edge (parameterised-width synchroniser plus rise/fall detector) SHALL be instantiated for the strobe group and the address/data group.

Verification
REQ-036 ALE cycle with Addr=0x2A, then write 0xA5 -> reg_address=0x2A, reg_datao=0xA5, reg_write high exactly 1 cycle, reg_bytecnt 0->1.
REQ-037 Addr=0x05, three reads with reg_datai model returning 0x11, 0x22, 0x33 -> USB_D shows each value while RDn is low; reg_bytecnt ends at 3; reg_read pulses = 3.
REQ-038 Second ALE phase after those reads -> reg_bytecnt=0 while reg_address keeps its old value until ALEn rises.
REQ-039 ALEn edge forced in the same cycle as a WRn rising edge -> no reg_write, proto_err=1 and held until reset.
REQ-040 reset_n pulsed low during RDDRIVE -> USB_D high-Z asynchronously, all outputs 0, FSM IDLE.
REQ-041 With the macro defined, 5 writes plus 4 reads -> access_cnt=9; without the macro -> access_cnt=0.
